// File: rtl/result_uart_streamer.sv
// Streams a run of 32-bit result words from the output SRAM to the UART as a framed byte packet.
// Define STREAM_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module result_uart_streamer #(
    parameter int          ADDR_W   = 6,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

`ifdef STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CNT, S_RD_REQ,
        S_RD_WAIT, S_BYTE, S_CHK, S_FIN
    } state_t;
    localparam state_t S_END = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CNT, S_RD_REQ,
        S_RD_WAIT, S_BYTE, S_FIN
    } state_t;
    localparam state_t S_END = S_FIN;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   LEFT_ONE = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   left_q;
    logic [7:0]        cnt_q;
    logic [31:0]       shreg;
    logic [1:0]        idx;
    logic              xfer;

    assign xfer     = tx_valid && tx_ready;
    assign mem_addr = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (start) state_nxt = S_HDR;
            S_HDR:     if (xfer) state_nxt = S_CNT;
            S_CNT:     if (xfer) state_nxt = (left_q != '0) ? S_RD_REQ : S_END;
            S_RD_REQ:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: state_nxt = S_BYTE;
            S_BYTE:
                if (xfer && idx == 2'd3)
                    state_nxt = (left_q != '0) ? S_RD_REQ : S_END;
`ifdef STREAM_CHECKSUM_EN
            S_CHK:     if (xfer) state_nxt = S_FIN;
`endif
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // left_q counts reads still to issue; it drops as each read goes out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            left_q <= '0;
            cnt_q  <= '0;
            shreg  <= '0;
            idx    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_q <= base_addr;
                left_q <= word_count;
                cnt_q  <= 8'(word_count);
            end
            if (state == S_RD_REQ) begin
                addr_q <= addr_q + ADDR_ONE;
                left_q <= left_q - LEFT_ONE;
            end
            if (state == S_RD_WAIT) begin
                shreg <= mem_rdata;
                idx   <= 2'd0;
            end
            if (state == S_BYTE && xfer) begin
                shreg <= {8'h00, shreg[31:8]};
                idx   <= idx + 2'd1;
            end
        end
    end

`ifdef STREAM_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (state == S_IDLE && start) begin
            csum <= '0;
        end else if (xfer && (state == S_CNT || state == S_BYTE)) begin
            csum <= csum ^ tx_data;
        end
    end
`endif

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: busy = 1'b0;
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
            end
            S_CNT: begin
                tx_valid = 1'b1;
                tx_data  = cnt_q;
            end
            S_RD_REQ:  mem_rd_en = 1'b1;
            S_RD_WAIT: ;
            S_BYTE: begin
                tx_valid = 1'b1;
                tx_data  = shreg[7:0];
            end
`ifdef STREAM_CHECKSUM_EN
            S_CHK: begin
                tx_valid = 1'b1;
                tx_data  = csum;
            end
`endif
            S_FIN: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_result_uart_streamer.sv
// Directed bench for result_uart_streamer: table of packet vectors plus
// hand-written sequences for restart, stall and mid-packet reset.
module tb_result_uart_streamer;

    localparam int AW = 6;
`ifdef STREAM_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    result_uart_streamer #(.ADDR_W(AW), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int ready_pct = 100;
    initial forever begin
        @(posedge clk);
        #1 tx_ready = ($urandom_range(99) < ready_pct);
    end

    logic [7:0]    got_q [$];
    logic [AW-1:0] rd_q [$];
    int            done_cnt = 0;
    int            stab_viol = 0;
    int            stab_checks = 0;
    logic          pv = 1'b0, pr = 1'b0;
    logic [7:0]    pd = '0;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (done) done_cnt++;
        if (!reset && pv && !pr) begin
            stab_checks++;
            if (!tx_valid || tx_data !== pd) stab_viol++;
        end
        pv <= tx_valid && !reset;
        pr <= tx_ready;
        pd <= tx_data;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q [$];

    task automatic build_exp(input logic [AW-1:0] b, input int n);
        logic [31:0] w;
        logic [7:0]  cs;
        logic [AW:0] nw;
        nw = (AW+1)'(n);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(nw));
        cs = 8'(nw);
        for (int i = 0; i < n; i++) begin
            w = mem[(int'(b) + i) % 64];
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        if (CK == 1) exp_q.push_back(cs);
    endtask

    task automatic check_pkt(input string name, input logic [AW-1:0] b,
                             input int n, input int sb, input int sr);
        build_exp(b, n);
        chk({name, " len"}, got_q.size() - sb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (sb + i < got_q.size())
                chk($sformatf("%s byte%0d", name, i), got_q[sb+i], exp_q[i]);
        chk({name, " reads"}, rd_q.size() - sr, n);
        for (int i = 0; i < n; i++)
            if (sr + i < rd_q.size())
                chk($sformatf("%s addr%0d", name, i), rd_q[sr+i],
                    32'((int'(b) + i) % 64));
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({name, " done_seen"}, done, 1'b1);
    endtask

    task automatic kick(input logic [AW-1:0] b, input int n);
        base_addr  = b;
        word_count = (AW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            cnt;
        int            pct;
        int            exp_len;
        int            exp_reads;
        logic [7:0]    exp_cnt_byte;
    } vec_t;

    vec_t vecs [6];
    int sb, sr, sd;

    initial begin
        vecs[0] = '{6'd0,  1,  100, 6 + CK,   1,  8'h01};
        vecs[1] = '{6'd0,  0,  100, 2 + CK,   0,  8'h00};
        vecs[2] = '{6'd62, 3,  100, 14 + CK,  3,  8'h03};
        vecs[3] = '{6'd5,  4,  30,  18 + CK,  4,  8'h04};
        vecs[4] = '{6'd10, 64, 100, 258 + CK, 64, 8'h40};
        vecs[5] = '{6'd63, 2,  50,  10 + CK,  2,  8'h02};

        for (int i = 0; i < 64; i++)
            mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} ^ 32'hC3C3_5A5A;
        mem[0] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst tx_data", tx_data, 8'h00);
        chk("rst mem_rd_en", mem_rd_en, 1'b0);
        chk("rst mem_addr", mem_addr, 6'd0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            ready_pct = vecs[v].pct;
            sb = got_q.size();
            sr = rd_q.size();
            sd = done_cnt;
            kick(vecs[v].base, vecs[v].cnt);
            chk($sformatf("v%0d busy", v), busy, 1'b1);
            wait_done($sformatf("v%0d", v));
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d done_cnt", v), done_cnt - sd, 1);
            chk($sformatf("v%0d idle", v), busy, 1'b0);
            chk($sformatf("v%0d tbl_len", v), got_q.size() - sb,
                vecs[v].exp_len);
            chk($sformatf("v%0d tbl_reads", v), rd_q.size() - sr,
                vecs[v].exp_reads);
            if (got_q.size() > sb + 1)
                chk($sformatf("v%0d cnt_byte", v), got_q[sb+1],
                    vecs[v].exp_cnt_byte);
            check_pkt($sformatf("v%0d", v), vecs[v].base, vecs[v].cnt, sb, sr);
            if (v == 0 && got_q.size() >= sb + 6) begin
                chk("v0 b2 44", got_q[sb+2], 8'h44);
                chk("v0 b5 11", got_q[sb+5], 8'h11);
                if (CK == 1 && got_q.size() >= sb + 7)
                    chk("v0 csum", got_q[sb+6], 8'h45);
            end
            if (v == 2 && rd_q.size() >= sr + 3) begin
                chk("v2 a0", rd_q[sr], 6'd62);
                chk("v2 a1", rd_q[sr+1], 6'd63);
                chk("v2 a2", rd_q[sr+2], 6'd0);
            end
        end

        // start while busy is ignored, start during FIN ignored, next cycle accepted
        ready_pct = 100;
        sb = got_q.size();
        sr = rd_q.size();
        sd = done_cnt;
        kick(6'd20, 2);
        repeat (4) @(negedge clk);
        kick(6'd40, 5);
        wait_done("mid");
        start = 1'b1;
        base_addr = 6'd30;
        word_count = 7'd1;
        @(negedge clk);
        start = 1'b0;
        chk("mid fin_start_ignored", busy, 1'b0);
        chk("mid done_cnt", done_cnt - sd, 1);
        check_pkt("mid", 6'd20, 2, sb, sr);
        sb = got_q.size();
        sr = rd_q.size();
        sd = done_cnt;
        kick(6'd30, 1);
        chk("after_fin busy", busy, 1'b1);
        wait_done("after_fin");
        repeat (2) @(negedge clk);
        chk("after_fin done_cnt", done_cnt - sd, 1);
        check_pkt("after_fin", 6'd30, 1, sb, sr);

        // indefinite stall holds the header byte
        ready_pct = 0;
        @(negedge clk);
        sb = got_q.size();
        sr = rd_q.size();
        kick(6'd0, 1);
        repeat (20) @(negedge clk);
        chk("stall valid", tx_valid, 1'b1);
        chk("stall data", tx_data, 8'hA5);
        chk("stall busy", busy, 1'b1);
        chk("stall nobytes", got_q.size() - sb, 0);
        ready_pct = 100;
        wait_done("stall");
        repeat (2) @(negedge clk);
        check_pkt("stall", 6'd0, 1, sb, sr);

        // reset during the second word
        sb = got_q.size();
        kick(6'd8, 3);
        for (int k = 0; k < 200 && got_q.size() - sb < 7; k++)
            @(negedge clk);
        chk("rstmid reached", got_q.size() - sb >= 7, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstmid tx_valid", tx_valid, 1'b0);
        chk("rstmid tx_data", tx_data, 8'h00);
        chk("rstmid busy", busy, 1'b0);
        chk("rstmid rd_en", mem_rd_en, 1'b0);
        chk("rstmid addr", mem_addr, 6'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb = got_q.size();
        sr = rd_q.size();
        sd = done_cnt;
        repeat (20) @(negedge clk);
        chk("rstmid nobytes", got_q.size() - sb, 0);
        chk("rstmid noreads", rd_q.size() - sr, 0);
        chk("rstmid nodone", done_cnt - sd, 0);
        chk("rstmid idle", busy, 1'b0);

        chk("stable_checks_seen", stab_checks > 0, 1'b1);
        chk("stability_violations", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
